// File: rtl/id_hazard_freeze_unit.sv
// ID/ALU freeze generator: a scoreboard shadows every instruction between
// ID/ALU entry and register-file write completion, and a multiply counter
// tracks ALU occupancy. Freeze is combinational so the ID/ALU register and
// the fetch/decode stages see it at the same edge that samples decode.
`timescale 1ns/1ps

module id_hazard_freeze_unit #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned PIPE_DEPTH  = 3,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   dec_valid,
  input  logic [4*NUM_SRC-1:0]   dec_src_add,
  input  logic [NUM_SRC-1:0]     dec_src_used,
  input  logic                   dec_wb_en,
  input  logic [3:0]             dec_wb_add,
  input  logic                   dec_base_wb_en,
  input  logic [3:0]             dec_base_reg_add,
  input  logic                   dec_is_mul,
  output logic                   freeze,
  output logic                   stall_if,
  output logic                   mul_busy,
  output logic [CNT_WIDTH-1:0]   hazard_count
);

  localparam int unsigned MW = $clog2(MUL_LATENCY) + 1;
  localparam logic [MW-1:0] MUL_LOAD = MW'(MUL_LATENCY - 1);

  // Scoreboard entry j holds the instruction j stages past ID/ALU entry.
  logic [PIPE_DEPTH-1:0] sb_v;
  logic [PIPE_DEPTH-1:0] sb_wb_en;
  logic [PIPE_DEPTH-1:0] sb_base_en;
  logic [3:0]            sb_wb_add   [PIPE_DEPTH];
  logic [3:0]            sb_base_add [PIPE_DEPTH];

  logic [MW-1:0] mul_cnt;
  logic          raw_hazard;
  logic          busy_int;
  logic          accept;

  // RAW check: any used source (except r15) matching a pending write in any entry.
  always_comb begin
    raw_hazard = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (dec_src_used[i] && (dec_src_add[4*i +: 4] != 4'hF)) begin
        for (int unsigned j = 0; j < PIPE_DEPTH; j++) begin
          if (sb_v[j] &&
              ((sb_wb_en[j]   && (sb_wb_add[j]   == dec_src_add[4*i +: 4])) ||
               (sb_base_en[j] && (sb_base_add[j] == dec_src_add[4*i +: 4]))))
            raw_hazard = 1'b1;
        end
      end
    end
    raw_hazard = raw_hazard & dec_valid;
  end

  // Freeze/stall/busy outputs, all forced low while reset is held.
  always_comb begin
    busy_int = (mul_cnt != '0);
    freeze   = ~reset & (raw_hazard | (dec_valid & busy_int));
    stall_if = freeze;
    mul_busy = ~reset & busy_int;
    accept   = dec_valid & ~freeze;
  end

  // Scoreboard shift; entry 0 takes the accepted instruction or a zero bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_v       <= '0;
      sb_wb_en   <= '0;
      sb_base_en <= '0;
      for (int unsigned j = 0; j < PIPE_DEPTH; j++) begin
        sb_wb_add[j]   <= '0;
        sb_base_add[j] <= '0;
      end
    end else begin
      for (int unsigned j = 1; j < PIPE_DEPTH; j++) begin
        sb_v[j]        <= sb_v[j-1];
        sb_wb_en[j]    <= sb_wb_en[j-1];
        sb_base_en[j]  <= sb_base_en[j-1];
        sb_wb_add[j]   <= sb_wb_add[j-1];
        sb_base_add[j] <= sb_base_add[j-1];
      end
      sb_v[0]        <= accept;
      sb_wb_en[0]    <= accept & dec_wb_en;
      sb_base_en[0]  <= accept & dec_base_wb_en;
      sb_wb_add[0]   <= accept ? dec_wb_add       : 4'h0;
      sb_base_add[0] <= accept ? dec_base_reg_add : 4'h0;
    end
  end

  // Multiply occupancy: load on acceptance of a multiply, else count down to zero.
  always_ff @(posedge clock) begin
    if (reset)
      mul_cnt <= '0;
    else if (accept && dec_is_mul)
      mul_cnt <= MUL_LOAD;
    else if (mul_cnt != '0)
      mul_cnt <= mul_cnt - 1'b1;
  end

  // Saturating count of frozen cycles.
  always_ff @(posedge clock) begin
    if (reset)
      hazard_count <= '0;
    else if (freeze && (hazard_count != '1))
      hazard_count <= hazard_count + 1'b1;
  end

endmodule

// File: tb/tb_id_hazard_freeze_unit.sv
// Scoreboard bench for id_hazard_freeze_unit: the driver computes expected
// outputs from a set-of-pending-writers model and queues them; a negedge
// monitor pops and compares against the DUT.
`timescale 1ns/1ps

module tb_id_hazard_freeze_unit;

  localparam int unsigned NS = 4;
  localparam int unsigned PD = 3;
  localparam int unsigned ML = 3;
  localparam int unsigned CW = 4;   // small so saturation is reachable
  localparam int          HC_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          dec_valid;
  logic [4*NS-1:0] dec_src_add;
  logic [NS-1:0] dec_src_used;
  logic          dec_wb_en;
  logic [3:0]    dec_wb_add;
  logic          dec_base_wb_en;
  logic [3:0]    dec_base_reg_add;
  logic          dec_is_mul;
  logic          freeze;
  logic          stall_if;
  logic          mul_busy;
  logic [CW-1:0] hazard_count;

  always #5 clock = ~clock;

  id_hazard_freeze_unit #(
    .NUM_SRC(NS), .PIPE_DEPTH(PD), .MUL_LATENCY(ML), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .dec_valid(dec_valid),
    .dec_src_add(dec_src_add), .dec_src_used(dec_src_used),
    .dec_wb_en(dec_wb_en), .dec_wb_add(dec_wb_add),
    .dec_base_wb_en(dec_base_wb_en), .dec_base_reg_add(dec_base_reg_add),
    .dec_is_mul(dec_is_mul), .freeze(freeze), .stall_if(stall_if),
    .mul_busy(mul_busy), .hazard_count(hazard_count)
  );

  typedef struct packed {
    logic          f;
    logic          mb;
    logic [CW-1:0] hc;
  } exp_t;

  typedef struct {
    int          acc;
    logic [15:0] mask;
  } wr_t;

  typedef struct packed {
    logic [15:0] src;
    logic [3:0]  used;
    logic        wbe;
    logic [3:0]  wb;
    logic        be;
    logic [3:0]  ba;
    logic        mul;
  } instr_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Reference model: writers accepted in cycle acc are pending during
  // cycles acc+1 .. acc+PD; a multiply accepted in cycle m keeps the ALU
  // busy during cycles m+1 .. m+ML-1.
  wr_t  writers[$];
  int   cyc      = 0;
  int   last_mul = -100;
  int   m_hc     = 0;
  logic last_accept;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_mul_busy();
    int d;
    d = cyc - last_mul;
    return (d >= 1) && (d <= int'(ML) - 1);
  endfunction

  function automatic logic m_raw();
    logic [3:0] s;
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(NS); i++) begin
      s = dec_src_add[4*i +: 4];
      if (dec_src_used[i] && s != 4'hF)
        foreach (writers[k])
          if ((cyc - writers[k].acc) <= int'(PD) && writers[k].mask[s]) hit = 1'b1;
    end
    return dec_valid && hit;
  endfunction

  // One clock cycle with the currently driven inputs.
  task automatic cycle(output logic df, output logic [CW-1:0] dhc);
    exp_t e;
    logic f;
    logic [15:0] mask;
    f    = !reset && dec_valid && (m_raw() || m_mul_busy());
    e.f  = f;
    e.mb = !reset && m_mul_busy();
    e.hc = CW'(m_hc);
    exp_q.push_back(e);
    #1;
    df  = freeze;
    dhc = hazard_count;
    @(posedge clock);
    if (reset) begin
      writers.delete();
      last_mul = -100;
      m_hc = 0;
      cyc = 0;
      last_accept = 1'b0;
    end else begin
      if (f && m_hc < HC_MAX) m_hc++;
      last_accept = dec_valid && !f;
      if (last_accept) begin
        mask = '0;
        if (dec_wb_en)      mask[dec_wb_add] = 1'b1;
        if (dec_base_wb_en) mask[dec_base_reg_add] = 1'b1;
        if (mask != '0) writers.push_back('{acc: cyc, mask: mask});
        if (dec_is_mul) last_mul = cyc;
      end
      cyc++;
      while (writers.size() > 0 && (cyc - writers[0].acc) > int'(PD)) void'(writers.pop_front());
    end
    #1;
  endtask

  function automatic instr_t ins(input logic [15:0] src, input logic [3:0] used,
                                 input logic wbe, input logic [3:0] wb,
                                 input logic be, input logic [3:0] ba, input logic mul);
    instr_t r;
    r.src = src; r.used = used; r.wbe = wbe; r.wb = wb;
    r.be = be; r.ba = ba; r.mul = mul;
    return r;
  endfunction

  task automatic drive(input instr_t x, input logic v);
    dec_valid        = v;
    dec_src_add      = x.src;
    dec_src_used     = x.used;
    dec_wb_en        = x.wbe;
    dec_wb_add       = x.wb;
    dec_base_wb_en   = x.be;
    dec_base_reg_add = x.ba;
    dec_is_mul       = x.mul;
  endtask

  // Hold an instruction until accepted; return cycles the DUT showed freeze.
  task automatic issue(input instr_t x, output int frozen);
    logic df;
    logic [CW-1:0] dhc;
    frozen = 0;
    drive(x, 1'b1);
    for (int k = 0; k < 16; k++) begin
      cycle(df, dhc);
      if (df === 1'b1) frozen++;
      if (last_accept) break;
    end
    if (!last_accept) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    logic df;
    logic [CW-1:0] dhc;
    dec_valid = 1'b0;
    repeat (n) cycle(df, dhc);
  endtask

  task automatic do_reset();
    logic df;
    logic [CW-1:0] dhc;
    dec_valid = 1'b0;
    reset = 1'b1;
    cycle(df, dhc);
    reset = 1'b0;
  endtask

  // Monitor: compare every DUT cycle against the queued expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("freeze",       32'(freeze),       32'(mon_e.f));
      check("stall_if",     32'(stall_if),     32'(mon_e.f));
      check("mul_busy",     32'(mul_busy),     32'(mon_e.mb));
      check("hazard_count", 32'(hazard_count), 32'(mon_e.hc));
    end
  end

  initial begin
    int fr;
    logic df;
    logic [CW-1:0] dhc;
    instr_t nop_w;
    instr_t r;

    reset = 1'b1;
    drive(ins(16'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0), 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("reset_hazard_count", 32'(hazard_count), 32'd0);
    check("reset_mul_busy",     32'(mul_busy),     32'd0);
    #1;

    // Adjacent RAW on r3.
    do_reset();
    issue(ins(16'h0, 4'h0, 1'b1, 4'd3, 1'b0, 4'h0, 1'b0), fr);
    issue(ins(16'h0003, 4'b0001, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0), fr);
    check("raw_adjacent_cycles", 32'(fr), 32'd3);
    idle(1);
    cycle(df, dhc);
    check("raw_adjacent_count", 32'(dhc), 32'd3);

    // One and three independent instructions in between.
    nop_w = ins(16'h0001, 4'b0001, 1'b1, 4'd6, 1'b0, 4'h0, 1'b0);
    issue(ins(16'h0, 4'h0, 1'b1, 4'd3, 1'b0, 4'h0, 1'b0), fr);
    issue(nop_w, fr);
    issue(ins(16'h0030, 4'b0010, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0), fr);
    check("raw_gap1_cycles", 32'(fr), 32'd2);
    idle(4);
    issue(ins(16'h0, 4'h0, 1'b1, 4'd3, 1'b0, 4'h0, 1'b0), fr);
    issue(nop_w, fr);
    issue(nop_w, fr);
    issue(nop_w, fr);
    issue(ins(16'h0300, 4'b0100, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0), fr);
    check("raw_gap3_cycles", 32'(fr), 32'd0);
    idle(4);

    // Base write-back to r5 read via rs4, then the same with no sources used.
    issue(ins(16'h0002, 4'b0001, 1'b1, 4'd1, 1'b1, 4'd5, 1'b0), fr);
    issue(ins(16'h5000, 4'b1000, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0), fr);
    check("base_wb_rs4_cycles", 32'(fr), 32'd3);
    idle(4);
    issue(ins(16'h0002, 4'b0001, 1'b1, 4'd1, 1'b1, 4'd5, 1'b0), fr);
    issue(ins(16'h5000, 4'b0000, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0), fr);
    check("base_wb_unused_cycles", 32'(fr), 32'd0);
    idle(4);

    // r15 never hazards.
    issue(ins(16'h0, 4'h0, 1'b1, 4'hF, 1'b1, 4'hF, 1'b0), fr);
    issue(ins(16'hFFFF, 4'b1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0), fr);
    check("pc_source_cycles", 32'(fr), 32'd0);
    idle(4);

    // Multiply then independent; multiply then dependent.
    issue(ins(16'h0, 4'h0, 1'b1, 4'd7, 1'b0, 4'h0, 1'b1), fr);
    issue(ins(16'h0001, 4'b0001, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0), fr);
    check("mul_indep_cycles", 32'(fr), 32'd2);
    idle(4);
    issue(ins(16'h0, 4'h0, 1'b1, 4'd7, 1'b0, 4'h0, 1'b1), fr);
    issue(ins(16'h0070, 4'b0010, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0), fr);
    check("mul_raw_cycles", 32'(fr), 32'd3);
    idle(4);

    // Reset during the second frozen cycle of a RAW stall.
    do_reset();
    issue(ins(16'h0, 4'h0, 1'b1, 4'd3, 1'b0, 4'h0, 1'b0), fr);
    drive(ins(16'h0003, 4'b0001, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0), 1'b1);
    cycle(df, dhc);
    check("pre_reset_freeze", 32'(df), 32'd1);
    reset = 1'b1;
    cycle(df, dhc);
    check("freeze_in_reset", 32'(df), 32'd0);
    reset = 1'b0;
    cycle(df, dhc);
    check("post_reset_freeze", 32'(df), 32'd0);
    check("post_reset_count", 32'(dhc), 32'd0);
    idle(4);

    // Saturation of the hazard counter.
    do_reset();
    for (int n = 0; n < 6; n++) begin
      issue(ins(16'h0, 4'h0, 1'b1, 4'd2, 1'b0, 4'h0, 1'b0), fr);
      issue(ins(16'h0020, 4'b0010, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0), fr);
    end
    idle(1);
    cycle(df, dhc);
    check("count_saturated", 32'(dhc), 32'(HC_MAX));

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < int'(NS); i++) begin
        int v;
        v = int'($urandom_range(0, 6));
        r.src[4*i +: 4] = (v == 6) ? 4'hF : 4'(v);
      end
      r.used = 4'($urandom);
      r.wbe  = 1'($urandom);
      r.wb   = ($urandom_range(0, 7) == 7) ? 4'hF : 4'($urandom_range(0, 5));
      r.be   = ($urandom_range(0, 3) == 0);
      r.ba   = 4'($urandom_range(0, 5));
      r.mul  = ($urandom_range(0, 7) == 0);
      drive(r, $urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 59) == 0);
      cycle(df, dhc);
    end
    reset = 1'b0;
    idle(2);

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) check("monitor_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_hazard_freeze_unit.md
Name: id_hazard_freeze_unit

Overview:
Generates the freeze input of the ID/ALU pipeline register. A scoreboard shadows every instruction in flight between decode and write-back completion. Freeze is raised while a decoded instruction reads a register still pending write, or while a multi-cycle multiply occupies the ALU. Each frozen cycle injects one zero bubble into the ID/ALU register and holds fetch/decode.

Parameters:
NUM_SRC, 4, number of decode source operands checked (rs1..rs4)
PIPE_DEPTH, 3, scoreboard stages from ID/ALU entry to register-file write completion
MUL_LATENCY, 3, total ALU-occupancy cycles of a multiply (>=1)
CNT_WIDTH, 16, width of saturating hazard statistics counter

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high; clears all state
dec_valid  in  1  decode stage holds a real instruction
dec_src_add  in  4*NUM_SRC  source register addresses, src i at [4i+3:4i]
dec_src_used  in  NUM_SRC  per-source read enable
dec_wb_en  in  1  instruction writes wb_add
dec_wb_add  in  4  destination register
dec_base_wb_en  in  1  instruction writes back base register (pre/post index)
dec_base_reg_add  in  4  base register written back
dec_is_mul  in  1  instruction is a multiply
freeze  out  1  to ID/ALU register freeze; 1 = insert bubble
stall_if  out  1  hold PC and IF/ID register; equals freeze
mul_busy  out  1  multiply counter nonzero
hazard_count  out  CNT_WIDTH  cycles frozen since reset, saturating

Behaviour:
- Scoreboard: PIPE_DEPTH entries {v, wb_en, wb_add, base_en, base_add}; entry 0 = instruction now in ID/ALU.
- Every posedge (reset low): entries shift 0->1->...->PIPE_DEPTH-1; oldest entry discarded.
- Entry 0 load: if dec_valid & ~freeze, load decode fields with v=1; otherwise load all-zero bubble (mirrors zeroed ID/ALU register).
- raw_hazard (combinational) = dec_valid and, for some i with dec_src_used[i], some entry with v=1 where (wb_en & wb_add==src_i) or (base_en & base_add==src_i).
- Register 15 (PC) never causes a hazard: src_i==4'hF is ignored.
- No forwarding: match in any entry, including the oldest, freezes.
- Multiply counter mul_cnt, width clog2(MUL_LATENCY)+1: loaded with MUL_LATENCY-1 when dec_valid & ~freeze & dec_is_mul. Otherwise decrements if nonzero. mul_busy = (mul_cnt!=0).
- freeze = dec_valid & (raw_hazard | mul_busy); combinational, same cycle as the decode inputs. Zero latency is required because the ID/ALU register samples it at the same edge.
- stall_if = freeze.
- The multiply itself is not frozen by its own load. A multiply with a RAW hazard waits; its counter loads only when it is accepted.
- Simultaneous RAW and mul_busy: freeze asserted once; both conditions resolve independently.
- hazard_count increments on every posedge with freeze=1, saturates at all-ones, never wraps.
- Reset (synchronous, may arrive mid-freeze or mid-multiply): scoreboard v=0, all fields 0, mul_cnt=0, hazard_count=0. While reset is high, freeze, stall_if and mul_busy are forced to 0. At the first edge after reset deasserts, state is empty and the next instruction is accepted.
- dec_valid=0: freeze=0, a bubble is loaded, counters still run.

Test Plan:
- A writes r3 (accepted edge 1), B reads r3 in the next cycle -> freeze=1 for exactly 3 cycles, B accepted on the 4th edge, hazard_count=3.
- A writes r3, independent C, then B reads r3 -> freeze for exactly 2 cycles. With 3 independent instructions between A and B -> no freeze.
- LDR with base write-back to r5, next instruction reads r5 via rs4 with dec_src_used=4'b1000 -> 3-cycle freeze. Same sequence with dec_src_used=0 -> no freeze.
- Source address 4'hF with an in-flight writer of r15 -> freeze=0.
- Multiply accepted, next instruction independent -> freeze=1 for 2 cycles, mul_busy 1 then 0. Multiply plus RAW on its destination -> freeze = max of the two (3 cycles).
- Assert reset during the 2nd frozen cycle of a RAW stall -> freeze=0 during reset. After release, the same reader is accepted immediately and hazard_count=0.
